// File: rtl/stress_eval.sv
// ---------------------------------------------------------------------------
// stress_eval
//
// N-channel stress evaluator. Every enabled channel averages a window of
// 2^WIN_LOG2 valid samples and compares that average with the previous
// window's average, classifying the channel as fallen, equal or risen. The
// per-channel verdicts are combined (OR or AND over enabled channels) into
// the gedaald / gelijk / gestegen flags used by the rocking-control FSM.
//
// Parameters
//   N_CH      number of sensor channels (1..8)
//   DATA_W    unsigned sample width per channel
//   WIN_LOG2  window length is 2^WIN_LOG2 valid samples (0..6)
//   TOL       dead band: |avg - prev| <= TOL counts as equal
//
// Ports
//   clk       rising-edge system clock
//   reset     synchronous, active-high reset
//   ch_data   packed samples, channel i at [i*DATA_W +: DATA_W]
//   ch_valid  per-channel one-cycle sample strobe
//   ch_mask   channel enable; 0 excludes the channel and clears its state
//   mode_and  0 = any enabled channel (OR), 1 = all enabled channels (AND)
//   ch_down   per-channel "last window fell by more than TOL"
//   ch_same   per-channel "last window stayed within +/-TOL"
//   ch_up     per-channel "last window rose by more than TOL"
//   gedaald   combined fallen flag
//   gelijk    combined equal flag
//   gestegen  combined risen flag
//   upd       one-cycle pulse: at least one channel produced a new verdict
//
// Handshake: a sample is consumed in every cycle where ch_valid[i] and
// ch_mask[i] are both high; there is no back-pressure, so a new sample may
// arrive every cycle. Verdict flags and upd appear one cycle after the
// completing sample is accepted.
// ---------------------------------------------------------------------------
module stress_eval #(
    parameter int N_CH     = 2,
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 2,
    parameter int TOL      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic                     mode_and,
    output logic [N_CH-1:0]          ch_down,
    output logic [N_CH-1:0]          ch_same,
    output logic [N_CH-1:0]          ch_up,
    output logic                     gedaald,
    output logic                     gelijk,
    output logic                     gestegen,
    output logic                     upd
);

    localparam int ACC_W = DATA_W + WIN_LOG2;
    // A window of one sample still needs a 1-bit counter; it simply never
    // leaves 0, so every valid sample completes a window.
    localparam int CNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << WIN_LOG2) - 1);
    localparam logic [DATA_W:0]  TOL_X    = (DATA_W + 1)'(TOL);

    typedef enum logic {
        BASE = 1'b0,  // collecting the baseline window, no verdict yet
        RUN  = 1'b1   // every completed window produces a verdict
    } state_t;

    // Per-channel FSM state, visible to checkers bound to this module.
    state_t              state_q [N_CH];
    state_t              state_d [N_CH];
    logic [ACC_W-1:0]    acc_q   [N_CH];
    logic [ACC_W-1:0]    acc_d   [N_CH];
    logic [CNT_W-1:0]    cnt_q   [N_CH];
    logic [CNT_W-1:0]    cnt_d   [N_CH];
    logic [DATA_W-1:0]   prev_q  [N_CH];
    logic [DATA_W-1:0]   prev_d  [N_CH];

    logic [N_CH-1:0]     down_d;
    logic [N_CH-1:0]     same_d;
    logic [N_CH-1:0]     up_d;
    logic [N_CH-1:0]     verdict;
    logic                any_en;
    logic                gedaald_d;
    logic                gelijk_d;
    logic                gestegen_d;

    always_comb begin
        logic [DATA_W-1:0] sample;
        logic [ACC_W-1:0]  sum;
        logic [DATA_W-1:0] avg;
        logic [DATA_W:0]   a_x;
        logic [DATA_W:0]   p_x;

        down_d  = ch_down;
        same_d  = ch_same;
        up_d    = ch_up;
        verdict = '0;
        sample  = '0;
        sum     = '0;
        avg     = '0;
        a_x     = '0;
        p_x     = '0;

        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            acc_d[i]   = acc_q[i];
            cnt_d[i]   = cnt_q[i];
            prev_d[i]  = prev_q[i];

            sample = ch_data[i*DATA_W +: DATA_W];
            sum    = acc_q[i] + ACC_W'(sample);
            avg    = DATA_W'(sum >> WIN_LOG2);
            // One extra bit so avg+TOL and prev+TOL cannot wrap.
            a_x    = {1'b0, avg};
            p_x    = {1'b0, prev_q[i]};

            if (!ch_mask[i]) begin
                // prev is left stale: BASE rewrites it before any compare.
                state_d[i] = BASE;
                acc_d[i]   = '0;
                cnt_d[i]   = '0;
                down_d[i]  = 1'b0;
                same_d[i]  = 1'b0;
                up_d[i]    = 1'b0;
            end else if (ch_valid[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Window complete: restart accumulation in this very
                    // cycle so back-to-back samples lose nothing.
                    acc_d[i]  = '0;
                    cnt_d[i]  = '0;
                    prev_d[i] = avg;
                    case (state_q[i])
                        BASE: state_d[i] = RUN;
                        RUN: begin
                            verdict[i] = 1'b1;
                            down_d[i]  = (a_x + TOL_X) < p_x;
                            up_d[i]    = a_x > (p_x + TOL_X);
                            same_d[i]  = !((a_x + TOL_X) < p_x) && !(a_x > (p_x + TOL_X));
                        end
                        default: state_d[i] = BASE;
                    endcase
                end else begin
                    acc_d[i] = sum;
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        // Masked channels already have zero next-state flags, so the OR form
        // needs no masking; the AND form treats disabled channels as "don't
        // care", and an empty enable set forces everything low.
        any_en     = |ch_mask;
        gedaald_d  = any_en & (mode_and ? &(down_d | ~ch_mask) : |down_d);
        gelijk_d   = any_en & (mode_and ? &(same_d | ~ch_mask) : |same_d);
        gestegen_d = any_en & (mode_and ? &(up_d   | ~ch_mask) : |up_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= BASE;
                acc_q[i]   <= '0;
                cnt_q[i]   <= '0;
                prev_q[i]  <= '0;
            end
            ch_down  <= '0;
            ch_same  <= '0;
            ch_up    <= '0;
            gedaald  <= 1'b0;
            gelijk   <= 1'b0;
            gestegen <= 1'b0;
            upd      <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                acc_q[i]   <= acc_d[i];
                cnt_q[i]   <= cnt_d[i];
                prev_q[i]  <= prev_d[i];
            end
            ch_down  <= down_d;
            ch_same  <= same_d;
            ch_up    <= up_d;
            gedaald  <= gedaald_d;
            gelijk   <= gelijk_d;
            gestegen <= gestegen_d;
            upd      <= |verdict;
        end
    end

endmodule

// File: tb/tb_stress_eval.sv
// ---------------------------------------------------------------------------
// tb_stress_eval
//
// Directed bench for stress_eval (N_CH=2, DATA_W=8, WIN_LOG2=2, TOL=2).
// Each table row holds the inputs for one clock cycle and the outputs
// expected just after the edge that samples them. A short hand-written
// sequence first holds reset with random strobes.
// ---------------------------------------------------------------------------
module tb_stress_eval;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ch_data;
    logic [1:0]  ch_valid;
    logic [1:0]  ch_mask;
    logic        mode_and;
    logic [1:0]  ch_down;
    logic [1:0]  ch_same;
    logic [1:0]  ch_up;
    logic        gedaald;
    logic        gelijk;
    logic        gestegen;
    logic        upd;

    always #5 clk = ~clk;

    stress_eval #(
        .N_CH     (2),
        .DATA_W   (8),
        .WIN_LOG2 (2),
        .TOL      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .ch_mask  (ch_mask),
        .mode_and (mode_and),
        .ch_down  (ch_down),
        .ch_same  (ch_same),
        .ch_up    (ch_up),
        .gedaald  (gedaald),
        .gelijk   (gelijk),
        .gestegen (gestegen),
        .upd      (upd)
    );

    // ---------------- vector table ----------------
    // exp = {ch_down, ch_same, ch_up, gedaald, gelijk, gestegen, upd}
    typedef struct {
        logic       rst;
        logic [1:0] mask;
        logic       mode;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t  vecs[$];
    string cur_name;
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic logic [9:0] got_vec();
        return {ch_down, ch_same, ch_up, gedaald, gelijk, gestegen, upd};
    endfunction

    task automatic add(input logic rst, input logic [1:0] mask, input logic mode,
                       input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] dn, input logic [1:0] sm, input logic [1:0] up,
                       input logic [2:0] comb, input logic u);
        vec_t v;
        v.rst   = rst;
        v.mask  = mask;
        v.mode  = mode;
        v.valid = valid;
        v.d0    = d0;
        v.d1    = d1;
        v.exp   = {dn, sm, up, comb, u};
        v.name  = cur_name;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int row, input logic [9:0] exp);
        logic [9:0] got;
        got = got_vec();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got dn=%b sm=%b up=%b flags=%b upd=%b, expected dn=%b sm=%b up=%b flags=%b upd=%b",
                     name, row, got[9:8], got[7:6], got[5:4], got[3:1], got[0],
                     exp[9:8], exp[7:6], exp[5:4], exp[3:1], exp[0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input int row);
        reset    = v.rst;
        ch_mask  = v.mask;
        mode_and = v.mode;
        ch_valid = v.valid;
        ch_data  = {v.d1, v.d0};
        @(posedge clk);
        #1;
        check(v.name, row, v.exp);
    endtask

    initial begin
        reset    = 1'b1;
        ch_mask  = 2'b11;
        mode_and = 1'b0;
        ch_valid = 2'b00;
        ch_data  = '0;

        // Reset held 3 cycles with random strobes and data: everything stays 0.
        for (int k = 0; k < 3; k++) begin
            ch_valid = 2'($urandom_range(0, 3));
            ch_data  = 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            check("reset_hold", k, 10'b0);
        end

        // Fall detection, OR mode.
        cur_name = "fall";
        add(1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b11, 0, 2'b01, 100, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b01, 90, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b01, 90, 0, 2'b01, 2'b00, 2'b00, 3'b100, 1);
        add(0, 2'b11, 0, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 3'b100, 0);

        // Tolerance band: 101 and 103 stay equal, 106 rises.
        cur_name = "tol";
        add(1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b11, 0, 2'b01, 100, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b01, 101, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b01, 102, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b01, 101, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b01, 102, 0, 2'b00, 2'b01, 2'b00, 3'b010, 1);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b01, 103, 0, 2'b00, 2'b01, 2'b00, 3'b010, 0);
        add(0, 2'b11, 0, 2'b01, 103, 0, 2'b00, 2'b01, 2'b00, 3'b010, 1);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b01, 106, 0, 2'b00, 2'b01, 2'b00, 3'b010, 0);
        add(0, 2'b11, 0, 2'b01, 106, 0, 2'b00, 2'b00, 2'b01, 3'b001, 1);

        // AND mode, simultaneous completion, mode and mask changes.
        cur_name = "and";
        add(1, 2'b11, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b11, 1, 2'b11, 100, 100, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 1, 2'b11, 90, 100, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 1, 2'b11, 90, 100, 2'b01, 2'b10, 2'b00, 3'b000, 1);
        add(0, 2'b11, 0, 2'b00, 0, 0, 2'b01, 2'b10, 2'b00, 3'b110, 0);
        add(0, 2'b11, 1, 2'b00, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 1, 2'b11, 80, 90, 2'b01, 2'b10, 2'b00, 3'b000, 0);
        add(0, 2'b11, 1, 2'b11, 80, 90, 2'b11, 2'b00, 2'b00, 3'b100, 1);
        add(0, 2'b01, 1, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 3'b100, 0);
        add(0, 2'b00, 1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);

        // Mask mid-window, re-enable baseline, reset mid-window.
        cur_name = "mask";
        add(1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b11, 0, 2'b10, 0, 50, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b10, 0, 50, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b10, 0, 50, 2'b00, 2'b10, 2'b00, 3'b010, 1);
        for (int k = 0; k < 2; k++) add(0, 2'b11, 0, 2'b10, 0, 60, 2'b00, 2'b10, 2'b00, 3'b010, 0);
        add(0, 2'b01, 0, 2'b10, 0, 60, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b01, 0, 2'b10, 0, 200, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b11, 0, 2'b10, 0, 60, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b10, 0, 70, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b10, 0, 70, 2'b00, 2'b00, 2'b10, 3'b001, 1);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b01, 10, 0, 2'b00, 2'b00, 2'b10, 3'b001, 0);
        add(1, 2'b11, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b11, 0, 2'b01, 200, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b11, 0, 2'b01, 200, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b11, 0, 2'b01, 200, 0, 2'b00, 2'b01, 2'b00, 3'b010, 1);

        // Range extremes: 255 -> 0 falls, 0 -> 255 rises, no wrap.
        cur_name = "extreme";
        add(1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 4; k++) add(0, 2'b01, 0, 2'b01, 255, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        for (int k = 0; k < 3; k++) add(0, 2'b01, 0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        add(0, 2'b01, 0, 2'b01, 0, 0, 2'b01, 2'b00, 2'b00, 3'b100, 1);
        for (int k = 0; k < 3; k++) add(0, 2'b01, 0, 2'b01, 255, 0, 2'b01, 2'b00, 2'b00, 3'b100, 0);
        add(0, 2'b01, 0, 2'b01, 255, 0, 2'b00, 2'b00, 2'b01, 3'b001, 1);

        for (int r = 0; r < vecs.size(); r++) begin
            apply(vecs[r], r);
        end

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
